// File: rtl/alu_arbiter.sv
// Round-robin sequencer that shares one external combinational ALU between
// the execute stage (requester 0) and the address/branch-compare unit (requester 1).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req0,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic [OPW-1:0]   i_op0,
  output logic             o_gnt0,
  output logic             o_vld0,
  input  logic             i_ack0,
  output logic [WIDTH-1:0] o_r0,
  input  logic             i_req1,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  input  logic [OPW-1:0]   i_op1,
  output logic             o_gnt1,
  output logic             o_vld1,
  input  logic             i_ack1,
  output logic [WIDTH-1:0] o_r1,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [OPW-1:0]   o_alu_op,
  input  logic [WIDTH-1:0] i_alu_r,
  output logic             o_busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  logic [0:0]       r_state;
  logic             r_last;
  logic             r_sel;
  logic [1:0]       r_gnt;
  logic [1:0]       r_vld;
  logic [WIDTH-1:0] r_res0;
  logic [WIDTH-1:0] r_res1;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;

  logic [1:0]       w_req;
  logic [1:0]       w_ack;
  logic [1:0]       w_elig;
  logic [1:0]       w_grant;

  assign w_req  = {i_req1, i_req0};
  assign w_ack  = {i_ack1, i_ack0};
  // A requester still holding an unacknowledged result sits out arbitration.
  assign w_elig = w_req & ~r_vld;

  // On a tie the requester that was not served last wins.
  assign w_grant[0] = (r_state == IDLE) && w_elig[0] && (!w_elig[1] || r_last);
  assign w_grant[1] = (r_state == IDLE) && w_elig[1] && (!w_elig[0] || !r_last);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_sel    <= 1'b0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant[0]) begin
            r_alu_a  <= i_a0;
            r_alu_b  <= i_b0;
            r_alu_op <= i_op0;
            r_sel    <= 1'b0;
            r_state  <= EXEC;
          end else if (w_grant[1]) begin
            r_alu_a  <= i_a1;
            r_alu_b  <= i_b1;
            r_alu_op <= i_op1;
            r_sel    <= 1'b1;
            r_state  <= EXEC;
          end
        end
        default: begin
          r_last  <= r_sel;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_gnt  <= '0;
      r_vld  <= '0;
      r_res0 <= '0;
      r_res1 <= '0;
    end else begin
      r_gnt <= w_grant;
      for (int i = 0; i < 2; i++) begin
        if (r_state == EXEC && r_sel == i[0]) begin
          r_vld[i] <= 1'b1;
        end else if (w_ack[i] && r_vld[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
      // Results persist after ack until the next completion overwrites them.
      if (r_state == EXEC && !r_sel) begin
        r_res0 <= i_alu_r;
      end
      if (r_state == EXEC && r_sel) begin
        r_res1 <= i_alu_r;
      end
    end
  end

  assign o_gnt0   = r_gnt[0];
  assign o_gnt1   = r_gnt[1];
  assign o_vld0   = r_vld[0];
  assign o_vld1   = r_vld[1];
  assign o_r0     = r_res0;
  assign o_r1     = r_res1;
  assign o_alu_a  = r_alu_a;
  assign o_alu_b  = r_alu_b;
  assign o_alu_op = r_alu_op;
  assign o_busy   = (r_state == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; the bench also plays the external ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, ack0, req1, ack1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  op0, op1;
  logic        gnt0, vld0, gnt1, vld1, busy;
  logic [31:0] r0, r1, alu_a, alu_b, alu_r;
  logic [2:0]  alu_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req0), .i_a0(a0), .i_b0(b0), .i_op0(op0),
    .o_gnt0(gnt0), .o_vld0(vld0), .i_ack0(ack0), .o_r0(r0),
    .i_req1(req1), .i_a1(a1), .i_b1(b1), .i_op1(op1),
    .o_gnt1(gnt1), .o_vld1(vld1), .i_ack1(ack1), .o_r1(r1),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_r(alu_r), .o_busy(busy)
  );

  always_comb begin
    alu_r = '0;
    case (alu_op)
      3'b000: alu_r = alu_a + alu_b;
      3'b001: alu_r = alu_a ^ alu_b;
      3'b010: alu_r = alu_a - alu_b;
      3'b100: alu_r = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      3'b101: alu_r = ~(alu_a | alu_b);
      3'b110: alu_r = alu_a & alu_b;
      3'b111: alu_r = alu_a | alu_b;
      default: alu_r = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt0"}, {31'd0, gnt0}, 32'd0);
    chk({tag, "_gnt1"}, {31'd0, gnt1}, 32'd0);
    chk({tag, "_vld0"}, {31'd0, vld0}, 32'd0);
    chk({tag, "_vld1"}, {31'd0, vld1}, 32'd0);
    chk({tag, "_r0"}, r0, 32'd0);
    chk({tag, "_r1"}, r1, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_op"}, {29'd0, alu_op}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; ack0 = 0; a0 = 0; b0 = 0; op0 = 0;
    req1 = 0; ack1 = 0; a1 = 0; b1 = 0; op1 = 0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_gnt0", {31'd0, gnt0}, 32'd0);
      chk("idle_gnt1", {31'd0, gnt1}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Single op: 5 - 3
    req0 = 1; a0 = 32'd5; b0 = 32'd3; op0 = 3'b010;
    tick();
    chk("single_gnt0", {31'd0, gnt0}, 32'd1);
    chk("single_gnt1", {31'd0, gnt1}, 32'd0);
    chk("single_alu_a", alu_a, 32'd5);
    chk("single_alu_b", alu_b, 32'd3);
    chk("single_alu_op", {29'd0, alu_op}, 32'd2);
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_vld0_early", {31'd0, vld0}, 32'd0);
    req0 = 0;
    tick();
    chk("single_vld0", {31'd0, vld0}, 32'd1);
    chk("single_r0", r0, 32'd2);
    chk("single_gnt0_pulse", {31'd0, gnt0}, 32'd0);
    chk("single_busy_off", {31'd0, busy}, 32'd0);
    ack0 = 1;
    tick();
    ack0 = 0;
    chk("single_ack_vld0", {31'd0, vld0}, 32'd0);
    chk("single_r0_hold", r0, 32'd2);

    // Asynchronous reset mid-run restores LAST=1
    rst = 1;
    #1;
    chk("async_rst_r0", r0, 32'd0);
    chk("async_rst_alu_a", alu_a, 32'd0);
    tick();
    rst = 0;

    // Simultaneous requests from reset: 0 wins the first tie
    req0 = 1; a0 = 32'd7; b0 = 32'd8; op0 = 3'b000;
    req1 = 1; a1 = 32'hFFFF_FFFF; b1 = 32'd0; op1 = 3'b100;
    tick();
    chk("sim_gnt0", {31'd0, gnt0}, 32'd1);
    chk("sim_gnt1", {31'd0, gnt1}, 32'd0);
    chk("sim_alu_op0", {29'd0, alu_op}, 32'd0);
    req0 = 0;
    tick();
    chk("sim_vld0", {31'd0, vld0}, 32'd1);
    chk("sim_r0", r0, 32'd15);
    chk("sim_no_gnt_exec", {31'd0, gnt1}, 32'd0);
    tick();
    chk("sim_gnt1_second", {31'd0, gnt1}, 32'd1);
    chk("sim_alu_a1", alu_a, 32'hFFFF_FFFF);
    chk("sim_alu_op1", {29'd0, alu_op}, 32'd4);
    req1 = 0;
    tick();
    chk("sim_vld1", {31'd0, vld1}, 32'd1);
    chk("sim_r1", r1, 32'd1);
    chk("sim_vld0_kept", {31'd0, vld0}, 32'd1);
    ack0 = 1; ack1 = 1;
    tick();
    ack0 = 0; ack1 = 0;
    chk("sim_ack_vld0", {31'd0, vld0}, 32'd0);
    chk("sim_ack_vld1", {31'd0, vld1}, 32'd0);

    // Requester 0 alone: F0F0 & FF00, leaves LAST=0
    req0 = 1; a0 = 32'h0000_F0F0; b0 = 32'h0000_FF00; op0 = 3'b110;
    tick();
    chk("and_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 0;
    tick();
    chk("and_r0", r0, 32'h0000_F000);
    ack0 = 1;
    tick();
    ack0 = 0;

    // Tie with LAST=0: requester 1 wins, then 0
    req0 = 1; a0 = 32'h0000_F0F0; b0 = 32'h0000_FF00; op0 = 3'b001;
    req1 = 1; a1 = 32'd1; b1 = 32'd2; op1 = 3'b111;
    tick();
    chk("alt_gnt1", {31'd0, gnt1}, 32'd1);
    chk("alt_gnt0_blocked", {31'd0, gnt0}, 32'd0);
    chk("alt_alu_op", {29'd0, alu_op}, 32'd7);
    req1 = 0;
    tick();
    chk("alt_vld1", {31'd0, vld1}, 32'd1);
    chk("alt_r1", r1, 32'd3);
    tick();
    chk("alt_gnt0", {31'd0, gnt0}, 32'd1);
    chk("alt_alu_op_xor", {29'd0, alu_op}, 32'd1);
    req0 = 0;
    tick();
    chk("alt_r0", r0, 32'h0000_0FF0);
    ack0 = 1; ack1 = 1;
    tick();
    ack0 = 0; ack1 = 0;

    // Back-pressure: requester 0 holds an unacked result with REQ0 still high
    req0 = 1; a0 = 32'd1; b0 = 32'd1; op0 = 3'b000;
    tick();
    chk("bp_gnt0", {31'd0, gnt0}, 32'd1);
    tick();
    chk("bp_r0", r0, 32'd2);
    req1 = 1; a1 = 32'd10; b1 = 32'd4; op1 = 3'b010;
    tick();
    chk("bp_gnt1_first", {31'd0, gnt1}, 32'd1);
    chk("bp_gnt0_first", {31'd0, gnt0}, 32'd0);
    tick();
    chk("bp_r1_first", r1, 32'd6);
    for (int i = 0; i < 2; i++) begin
      ack1 = 1;
      tick();
      ack1 = 0;
      chk("bp_ackcycle_gnt1", {31'd0, gnt1}, 32'd0);
      chk("bp_ackcycle_gnt0", {31'd0, gnt0}, 32'd0);
      chk("bp_ackcycle_vld1", {31'd0, vld1}, 32'd0);
      tick();
      chk("bp_gnt1", {31'd0, gnt1}, 32'd1);
      chk("bp_gnt0", {31'd0, gnt0}, 32'd0);
      tick();
      chk("bp_vld1", {31'd0, vld1}, 32'd1);
      chk("bp_r1", r1, 32'd6);
      chk("bp_vld0_held", {31'd0, vld0}, 32'd1);
    end

    // Reserved opcode 011 with all-ones operands returns 0
    ack1 = 1;
    tick();
    ack1 = 0;
    a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; op1 = 3'b011;
    tick();
    chk("rsv_gnt1", {31'd0, gnt1}, 32'd1);
    chk("rsv_alu_op", {29'd0, alu_op}, 32'd3);
    chk("rsv_alu_b", alu_b, 32'hFFFF_FFFF);
    req1 = 0;
    tick();
    chk("rsv_vld1", {31'd0, vld1}, 32'd1);
    chk("rsv_r1", r1, 32'd0);

    // Release requester 0, then reset during its EXEC cycle
    ack0 = 1;
    tick();
    ack0 = 0;
    chk("rel_vld0", {31'd0, vld0}, 32'd0);
    chk("rel_gnt0", {31'd0, gnt0}, 32'd0);
    tick();
    chk("rel_gnt0_late", {31'd0, gnt0}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd1);
    rst = 1;
    #1;
    chk_all_zero("midop");
    tick();
    chk("midop_vld0_held", {31'd0, vld0}, 32'd0);
    rst = 0;
    tick();
    chk("post_rst_gnt0", {31'd0, gnt0}, 32'd1);
    chk("post_rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("post_rst_alu_a", alu_a, 32'd1);
    req0 = 0;
    tick();
    chk("post_rst_vld0", {31'd0, vld0}, 32'd1);
    chk("post_rst_r0", r0, 32'd2);
    chk("post_rst_vld1", {31'd0, vld1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
